trap_ctrl: RTL and testbench
============================

# trap_ctrl

Machine-mode trap sequencer that drives the exception write port of the CSR file. It sits beside the commit stage and takes synchronous exceptions, enabled interrupts and MRET. For each accepted event it computes the mcause, mepc, mtval, mstatus and mip update values, then pulses the CSR write strobes. Finally it flushes the pipeline and redirects fetch to the handler (mtvec) or the return address (mepc) over a valid/ready handshake.

## Interface
- XLEN, 32, data/address width
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-low reset
- commit_valid_i  in  1  instruction at commit stage is valid
- pc_i  in  XLEN  PC of committing instruction
- inst_i  in  32  encoding of committing instruction
- badaddr_i  in  XLEN  faulting address (branch target / load-store address)
- e_inst_misaligned_i, e_illegal_inst_i, e_ecall_i, e_ebreak_i, e_load_misaligned_i, e_store_misaligned_i  in  1 each  synchronous exception flags
- mret_i  in  1  committing instruction is MRET
- meip_i, mtip_i, msip_i  in  1 each  raw external/timer/software interrupt lines
- mstatus_i  in  XLEN  current mstatus from CSR file
- mie_i  in  XLEN  current mie from CSR file
- we_exc_o  out  1  one-cycle CSR trap-write strobe
- is_int_o  out  1  trap is an interrupt; qualifies mcause/mip write
- sel_exc_nret_o  out  1  1 selects mepc (MRET return), 0 selects mtvec
- mcause_d_o, mepc_d_o, mtval_d_o, mstatus_d_o, mip_d_o  out  XLEN each  CSR update values
- flush_o  out  1  kill all younger pipeline instructions
- stall_o  out  1  freeze fetch/decode
- redirect_valid_o  out  1  new PC available at CSR exc_ret_addr
- redirect_ready_i  in  1  fetch accepted redirect

## Operation
- States: IDLE, TRAP_WR, MRET_WR, REDIRECT.
- IDLE: when commit_valid_i=1, evaluate the pending cause through the priority encoder.
- Interrupt pending = mstatus_i[3] & mie_i[k] & line, for k=11 (MEI), 3 (MSI), 7 (MTI).
- Priority, highest first: MEI > MSI > MTI > inst_misaligned(0) > illegal(2) > ebreak(3) > ecall(11) > load_misaligned(4) > store_misaligned(6) > MRET.
- Trap accepted → TRAP_WR. Capture values:
  - mcause = {is_int, 26'b0, code}.
  - mepc = pc_i with bits [1:0] forced to 0.
  - mtval = inst_i for illegal; badaddr_i for misaligned causes; 0 otherwise.
  - mip = {20'b0, meip, 3'b0, mtip, 3'b0, msip, 3'b0}.
  - mstatus = mstatus_i with MPIE[7]←MIE[3], MIE[3]←0, MPP[12:11]←2'b11.
- MRET accepted → MRET_WR. mstatus = mstatus_i with MIE[3]←MPIE[7], MPIE[7]←1, MPP←2'b11. mcause, mepc and mtval outputs are held unchanged.
- TRAP_WR: we_exc_o=1, is_int_o=is_int, flush_o=1, sel_exc_nret_o=0, for one cycle → REDIRECT.
- MRET_WR: flush_o=1, sel_exc_nret_o=1, we_exc_o=0, for one cycle → REDIRECT.
- REDIRECT: redirect_valid_o=1; sel_exc_nret_o holds its value from the previous state. Leave to IDLE on the cycle redirect_valid_o & redirect_ready_i.
- stall_o=1 in every state except IDLE.
- All inputs are ignored outside IDLE: the pipeline is being flushed, and interrupts stay pending on their lines.

## Timing
- All outputs are registered.
- Reset values: every output 0; state IDLE.
- Event sampled at edge N while in IDLE:
  - N+1: TRAP_WR/MRET_WR outputs visible.
  - N+2: redirect_valid_o=1 (earliest).
  - Minimum turnaround back to IDLE: 3 cycles, when redirect_ready_i is already high.
- redirect_valid_o, once high, stays high until accepted. sel_exc_nret_o is stable for the whole handshake.
- Simultaneous interrupt and exception: the interrupt wins; mepc = pc_i, so the instruction re-executes after return.
- Simultaneous exception and MRET: the exception wins.
- commit_valid_i=0: no event is taken, even with interrupt lines high.
- Asynchronous reset mid-sequence (any state): immediate return to IDLE with all outputs 0. No partial CSR write is retried.

## Structure
- Package trap_pkg holds:
  - cause code constants (0, 2, 3, 4, 6, 11; interrupt 3, 7, 11);
  - mstatus bit indices (MIE=3, MPIE=7, MPP=12:11);
  - the 2-bit state enum.
- One combinational sub-module, trap_prio: takes the flags, interrupt lines, mie and mstatus.MIE; returns take_trap, is_int, code[4:0], take_mret.
- The FSM and capture registers live in trap_ctrl.

## Test plan
- Illegal instruction: pc_i=0x100, inst_i=0xFFFFFFFF, redirect_ready_i=1 → we_exc_o pulse at N+1 with mcause=2, mepc=0x100, mtval=0xFFFFFFFF, mstatus.MIE=0; redirect at N+2 with sel_exc_nret_o=0.
- Timer interrupt: mstatus_i=0x1808, mie_i=0x80, mtip_i=1, ecall also asserted → mcause=0x80000007, is_int_o=1, mip_d_o=0x80, mstatus_d_o=0x1880.
- Masked interrupt: mie_i=0, meip_i=1 for 10 cycles → no trap, stall_o stays 0.
- MRET: mstatus_i=0x1880 → MRET_WR produces mstatus_d_o=0x1888 with we_exc_o=0; redirect with sel_exc_nret_o=1.
- Backpressure: redirect_ready_i=0 for 5 cycles → redirect_valid_o and stall_o held; new exception flags ignored; IDLE on the cycle after ready rises.
- Reset asserted in REDIRECT → all outputs 0 immediately; after release, the next ecall yields mcause=11.

Source files
------------

// File: rtl/trap_ctrl_pkg.sv
// Shared constants, state encoding and CSR update helpers for the machine-mode trap sequencer.
package trap_pkg;

    localparam int unsigned XLEN = 32;

    // Synchronous exception cause codes
    localparam logic [4:0] CAUSE_INST_MISALIGNED  = 5'd0;
    localparam logic [4:0] CAUSE_ILLEGAL_INST     = 5'd2;
    localparam logic [4:0] CAUSE_BREAKPOINT       = 5'd3;
    localparam logic [4:0] CAUSE_LOAD_MISALIGNED  = 5'd4;
    localparam logic [4:0] CAUSE_STORE_MISALIGNED = 5'd6;
    localparam logic [4:0] CAUSE_ECALL_M          = 5'd11;

    // Interrupt cause codes double as their mie/mip bit positions
    localparam logic [4:0] INT_MSI = 5'd3;
    localparam logic [4:0] INT_MTI = 5'd7;
    localparam logic [4:0] INT_MEI = 5'd11;

    localparam int unsigned MSTATUS_MIE    = 3;
    localparam int unsigned MSTATUS_MPIE   = 7;
    localparam int unsigned MSTATUS_MPP_HI = 12;
    localparam int unsigned MSTATUS_MPP_LO = 11;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_TRAP_WR  = 2'd1,
        ST_MRET_WR  = 2'd2,
        ST_REDIRECT = 2'd3
    } trap_state_e;

    function automatic logic [XLEN-1:0] mstatus_on_trap(input logic [XLEN-1:0] ms);
        logic [XLEN-1:0] r;
        r                                = ms;
        r[MSTATUS_MPIE]                  = ms[MSTATUS_MIE];
        r[MSTATUS_MIE]                   = 1'b0;
        r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        return r;
    endfunction

    function automatic logic [XLEN-1:0] mstatus_on_mret(input logic [XLEN-1:0] ms);
        logic [XLEN-1:0] r;
        r                                = ms;
        r[MSTATUS_MIE]                   = ms[MSTATUS_MPIE];
        r[MSTATUS_MPIE]                  = 1'b1;
        r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        return r;
    endfunction

    function automatic logic [XLEN-1:0] mcause_value(input logic is_int, input logic [4:0] code);
        return {is_int, {(XLEN-6){1'b0}}, code};
    endfunction

    function automatic logic [XLEN-1:0] mip_value(input logic meip, input logic mtip, input logic msip);
        logic [XLEN-1:0] r;
        r                = '0;
        r[int'(INT_MEI)] = meip;
        r[int'(INT_MTI)] = mtip;
        r[int'(INT_MSI)] = msip;
        return r;
    endfunction

    function automatic logic is_misaligned_cause(input logic [4:0] code);
        return (code == CAUSE_INST_MISALIGNED) || (code == CAUSE_LOAD_MISALIGNED) ||
               (code == CAUSE_STORE_MISALIGNED);
    endfunction

endpackage

// File: rtl/trap_ctrl_if.sv
// CSR exception write port plus the fetch redirect handshake driven by trap_ctrl.
interface trap_ctrl_if;
    import trap_pkg::*;

    logic            we_exc_o;
    logic            is_int_o;
    logic            sel_exc_nret_o;
    logic [XLEN-1:0] mcause_d_o;
    logic [XLEN-1:0] mepc_d_o;
    logic [XLEN-1:0] mtval_d_o;
    logic [XLEN-1:0] mstatus_d_o;
    logic [XLEN-1:0] mip_d_o;
    logic            redirect_valid_o;
    logic            redirect_ready_i;

    modport master (
        output we_exc_o, is_int_o, sel_exc_nret_o,
        output mcause_d_o, mepc_d_o, mtval_d_o, mstatus_d_o, mip_d_o,
        output redirect_valid_o,
        input  redirect_ready_i
    );

    modport slave (
        input  we_exc_o, is_int_o, sel_exc_nret_o,
        input  mcause_d_o, mepc_d_o, mtval_d_o, mstatus_d_o, mip_d_o,
        input  redirect_valid_o,
        output redirect_ready_i
    );

endinterface

// File: rtl/trap_ctrl_prio.sv
// Combinational cause selection: enabled interrupts first, then exceptions, MRET last.
module trap_prio
    import trap_pkg::*;
(
    input  logic            e_inst_misaligned,
    input  logic            e_illegal_inst,
    input  logic            e_ecall,
    input  logic            e_ebreak,
    input  logic            e_load_misaligned,
    input  logic            e_store_misaligned,
    input  logic            mret,
    input  logic            meip,
    input  logic            mtip,
    input  logic            msip,
    input  logic [XLEN-1:0] mie,
    input  logic            mstatus_mie,
    output logic            take_trap,
    output logic            is_int,
    output logic [4:0]      code,
    output logic            take_mret
);

    localparam int unsigned N_INT = 3;
    localparam int unsigned N_EXC = 6;

    // Index 0 is the highest priority in both tables
    localparam logic [4:0] INT_CODE [N_INT] = '{INT_MEI, INT_MSI, INT_MTI};
    localparam logic [4:0] EXC_CODE [N_EXC] = '{CAUSE_INST_MISALIGNED, CAUSE_ILLEGAL_INST,
                                                CAUSE_BREAKPOINT, CAUSE_ECALL_M,
                                                CAUSE_LOAD_MISALIGNED, CAUSE_STORE_MISALIGNED};

    logic [N_INT-1:0] int_line;
    logic [N_INT-1:0] int_pend;
    logic [N_EXC-1:0] exc_flag;
    logic             mie_unused;

    assign int_line = {mtip, msip, meip};
    assign exc_flag = {e_store_misaligned, e_load_misaligned, e_ecall,
                       e_ebreak, e_illegal_inst, e_inst_misaligned};

    genvar gi;
    for (gi = 0; gi < N_INT; gi++) begin : g_int_pend
        assign int_pend[gi] = mstatus_mie & mie[int'(INT_CODE[gi])] & int_line[gi];
    end

    assign mie_unused = ^{mie[XLEN-1:12], mie[10:8], mie[6:4], mie[2:0]};

    // Scan lowest priority first so the highest pending source is the last writer
    always_comb begin
        take_trap = 1'b0;
        is_int    = 1'b0;
        code      = '0;
        for (int i = N_EXC - 1; i >= 0; i--) begin
            if (exc_flag[i]) begin
                take_trap = 1'b1;
                code      = EXC_CODE[i];
            end
        end
        for (int i = N_INT - 1; i >= 0; i--) begin
            if (int_pend[i]) begin
                take_trap = 1'b1;
                is_int    = 1'b1;
                code      = INT_CODE[i];
            end
        end
        take_mret = mret & ~take_trap;
    end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: captures CSR update values, strobes the write, then redirects fetch.
module trap_ctrl
    import trap_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            commit_valid_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [31:0]     inst_i,
    input  logic [XLEN-1:0] badaddr_i,
    input  logic            e_inst_misaligned_i,
    input  logic            e_illegal_inst_i,
    input  logic            e_ecall_i,
    input  logic            e_ebreak_i,
    input  logic            e_load_misaligned_i,
    input  logic            e_store_misaligned_i,
    input  logic            mret_i,
    input  logic            meip_i,
    input  logic            mtip_i,
    input  logic            msip_i,
    input  logic [XLEN-1:0] mstatus_i,
    input  logic [XLEN-1:0] mie_i,
    output logic            flush_o,
    output logic            stall_o,
    trap_ctrl_if.master     csr
);

    trap_state_e     state_reg;
    logic            we_exc_reg;
    logic            is_int_reg;
    logic            sel_exc_nret_reg;
    logic            flush_reg;
    logic            stall_reg;
    logic            redirect_valid_reg;
    logic [XLEN-1:0] mcause_reg;
    logic [XLEN-1:0] mepc_reg;
    logic [XLEN-1:0] mtval_reg;
    logic [XLEN-1:0] mstatus_reg;
    logic [XLEN-1:0] mip_reg;

    logic            take_trap;
    logic            is_int;
    logic [4:0]      code;
    logic            take_mret;
    logic [XLEN-1:0] mtval_next;
    logic            pc_unused;

    trap_prio u_prio (
        .e_inst_misaligned  (e_inst_misaligned_i),
        .e_illegal_inst     (e_illegal_inst_i),
        .e_ecall            (e_ecall_i),
        .e_ebreak           (e_ebreak_i),
        .e_load_misaligned  (e_load_misaligned_i),
        .e_store_misaligned (e_store_misaligned_i),
        .mret               (mret_i),
        .meip               (meip_i),
        .mtip               (mtip_i),
        .msip               (msip_i),
        .mie                (mie_i),
        .mstatus_mie        (mstatus_i[MSTATUS_MIE]),
        .take_trap          (take_trap),
        .is_int             (is_int),
        .code               (code),
        .take_mret          (take_mret)
    );

    // mepc is word aligned, so the low PC bits never reach a register
    assign pc_unused = ^pc_i[1:0];

    always_comb begin
        mtval_next = '0;
        if (!is_int && code == CAUSE_ILLEGAL_INST) begin
            mtval_next = inst_i;
        end else if (!is_int && is_misaligned_cause(code)) begin
            mtval_next = badaddr_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg          <= ST_IDLE;
            we_exc_reg         <= 1'b0;
            is_int_reg         <= 1'b0;
            sel_exc_nret_reg   <= 1'b0;
            flush_reg          <= 1'b0;
            stall_reg          <= 1'b0;
            redirect_valid_reg <= 1'b0;
            mcause_reg         <= '0;
            mepc_reg           <= '0;
            mtval_reg          <= '0;
            mstatus_reg        <= '0;
            mip_reg            <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (commit_valid_i && take_trap) begin
                        state_reg        <= ST_TRAP_WR;
                        we_exc_reg       <= 1'b1;
                        is_int_reg       <= is_int;
                        flush_reg        <= 1'b1;
                        sel_exc_nret_reg <= 1'b0;
                        stall_reg        <= 1'b1;
                        mcause_reg       <= mcause_value(is_int, code);
                        mepc_reg         <= {pc_i[XLEN-1:2], 2'b00};
                        mtval_reg        <= mtval_next;
                        mstatus_reg      <= mstatus_on_trap(mstatus_i);
                        mip_reg          <= mip_value(meip_i, mtip_i, msip_i);
                    end else if (commit_valid_i && take_mret) begin
                        // mcause/mepc/mtval keep their last trap values
                        state_reg        <= ST_MRET_WR;
                        flush_reg        <= 1'b1;
                        sel_exc_nret_reg <= 1'b1;
                        stall_reg        <= 1'b1;
                        mstatus_reg      <= mstatus_on_mret(mstatus_i);
                    end
                end
                ST_TRAP_WR, ST_MRET_WR: begin
                    state_reg          <= ST_REDIRECT;
                    we_exc_reg         <= 1'b0;
                    is_int_reg         <= 1'b0;
                    flush_reg          <= 1'b0;
                    redirect_valid_reg <= 1'b1;
                end
                ST_REDIRECT: begin
                    if (csr.redirect_ready_i) begin
                        state_reg          <= ST_IDLE;
                        redirect_valid_reg <= 1'b0;
                        stall_reg          <= 1'b0;
                        sel_exc_nret_reg   <= 1'b0;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign flush_o              = flush_reg;
    assign stall_o              = stall_reg;
    assign csr.we_exc_o         = we_exc_reg;
    assign csr.is_int_o         = is_int_reg;
    assign csr.sel_exc_nret_o   = sel_exc_nret_reg;
    assign csr.mcause_d_o       = mcause_reg;
    assign csr.mepc_d_o         = mepc_reg;
    assign csr.mtval_d_o        = mtval_reg;
    assign csr.mstatus_d_o      = mstatus_reg;
    assign csr.mip_d_o          = mip_reg;
    assign csr.redirect_valid_o = redirect_valid_reg;

endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: a spec-level model queues expected CSR writes, a monitor checks them.
module tb_trap_ctrl;
    import trap_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        commit_valid_i;
    logic [31:0] pc_i, inst_i, badaddr_i, mstatus_i, mie_i;
    logic        e_inst_misaligned_i, e_illegal_inst_i, e_ecall_i, e_ebreak_i;
    logic        e_load_misaligned_i, e_store_misaligned_i, mret_i;
    logic        meip_i, mtip_i, msip_i;
    logic        flush_o, stall_o;

    trap_ctrl_if bus ();

    trap_ctrl dut (
        .clk_i                (clk_i),
        .rst_i                (rst_i),
        .commit_valid_i       (commit_valid_i),
        .pc_i                 (pc_i),
        .inst_i               (inst_i),
        .badaddr_i            (badaddr_i),
        .e_inst_misaligned_i  (e_inst_misaligned_i),
        .e_illegal_inst_i     (e_illegal_inst_i),
        .e_ecall_i            (e_ecall_i),
        .e_ebreak_i           (e_ebreak_i),
        .e_load_misaligned_i  (e_load_misaligned_i),
        .e_store_misaligned_i (e_store_misaligned_i),
        .mret_i               (mret_i),
        .meip_i               (meip_i),
        .mtip_i               (mtip_i),
        .msip_i               (msip_i),
        .mstatus_i            (mstatus_i),
        .mie_i                (mie_i),
        .flush_o              (flush_o),
        .stall_o              (stall_o),
        .csr                  (bus)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit          is_mret;
        bit          is_int;
        logic [31:0] mcause, mepc, mtval, mstatus, mip;
        int          edge_no;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_txn    = 0;
    int          edge_cnt = 0;
    bit          mon_en   = 1'b0;
    bit          m_busy   = 1'b0;
    bit          m_wr     = 1'b0;
    bit          cur_sel  = 1'b0;
    logic [31:0] m_last_cause = '0, m_last_epc = '0, m_last_tval = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        commit_valid_i = 0; pc_i = 0; inst_i = 0; badaddr_i = 0;
        e_inst_misaligned_i = 0; e_illegal_inst_i = 0; e_ecall_i = 0; e_ebreak_i = 0;
        e_load_misaligned_i = 0; e_store_misaligned_i = 0; mret_i = 0;
        meip_i = 0; mtip_i = 0; msip_i = 0; mstatus_i = 0; mie_i = 0;
        bus.redirect_ready_i = 1'b1;
    endtask

    task automatic model_reset();
        m_busy = 0; m_wr = 0; cur_sel = 0;
        m_last_cause = 0; m_last_epc = 0; m_last_tval = 0;
        exp_q.delete();
    endtask

    // Architectural reference: derives the accepted event from the trap rules directly
    task automatic model_edge();
        exp_t e;
        bit   gie, ev;
        int   code;
        edge_cnt++;
        if (!m_busy) begin
            if (commit_valid_i) begin
                gie = mstatus_i[3];
                ev = 1; e.is_mret = 0; e.is_int = 0; e.mtval = 0;
                if      (gie && mie_i[11] && meip_i) begin e.is_int = 1; code = 11; end
                else if (gie && mie_i[3]  && msip_i) begin e.is_int = 1; code = 3;  end
                else if (gie && mie_i[7]  && mtip_i) begin e.is_int = 1; code = 7;  end
                else if (e_inst_misaligned_i)  begin code = 0;  e.mtval = badaddr_i; end
                else if (e_illegal_inst_i)     begin code = 2;  e.mtval = inst_i;    end
                else if (e_ebreak_i)           code = 3;
                else if (e_ecall_i)            code = 11;
                else if (e_load_misaligned_i)  begin code = 4;  e.mtval = badaddr_i; end
                else if (e_store_misaligned_i) begin code = 6;  e.mtval = badaddr_i; end
                else if (mret_i)               begin e.is_mret = 1; code = 0; end
                else ev = 0;
                if (ev) begin
                    e.edge_no = edge_cnt;
                    if (e.is_mret) begin
                        e.mcause  = m_last_cause;
                        e.mepc    = m_last_epc;
                        e.mtval   = m_last_tval;
                        e.mstatus = mstatus_i;
                        e.mstatus[3] = mstatus_i[7];
                        e.mstatus[7] = 1'b1;
                        e.mstatus[12:11] = 2'b11;
                        e.mip = 0;
                    end else begin
                        e.mcause  = (e.is_int ? 32'h8000_0000 : 32'h0) + code;
                        e.mepc    = pc_i & 32'hFFFF_FFFC;
                        e.mstatus = mstatus_i;
                        e.mstatus[7] = mstatus_i[3];
                        e.mstatus[3] = 1'b0;
                        e.mstatus[12:11] = 2'b11;
                        e.mip = (meip_i ? 32'h800 : 0) + (mtip_i ? 32'h80 : 0) + (msip_i ? 32'h8 : 0);
                        m_last_cause = e.mcause; m_last_epc = e.mepc; m_last_tval = e.mtval;
                    end
                    exp_q.push_back(e);
                    m_busy = 1; m_wr = 1;
                end
            end
        end else if (m_wr) begin
            m_wr = 0;
        end else if (bus.redirect_ready_i) begin
            m_busy = 0;
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        model_edge();
        @(negedge clk_i);
    endtask

    always @(negedge clk_i) begin
        if (mon_en) begin
            check("stall", {31'b0, stall_o}, {31'b0, m_busy});
            check("redirect_valid", {31'b0, bus.redirect_valid_o}, {31'b0, m_busy & ~m_wr});
            check("flush", {31'b0, flush_o}, {31'b0, m_wr});
            if (flush_o) begin
                if (exp_q.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL scoreboard: flush seen, got event expected none (t=%0t)", $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    n_txn++;
                    check("latency_edge", edge_cnt, mon_e.edge_no);
                    check("we_exc", {31'b0, bus.we_exc_o}, {31'b0, ~mon_e.is_mret});
                    check("is_int", {31'b0, bus.is_int_o}, {31'b0, mon_e.is_int});
                    check("sel_wr", {31'b0, bus.sel_exc_nret_o}, {31'b0, mon_e.is_mret});
                    check("mcause", bus.mcause_d_o, mon_e.mcause);
                    check("mepc", bus.mepc_d_o, mon_e.mepc);
                    check("mtval", bus.mtval_d_o, mon_e.mtval);
                    check("mstatus", bus.mstatus_d_o, mon_e.mstatus);
                    if (!mon_e.is_mret) check("mip", bus.mip_d_o, mon_e.mip);
                    cur_sel = mon_e.is_mret;
                    $display("txn %0d: %s int=%0b mcause=%08h mepc=%08h mtval=%08h mstatus=%08h",
                             n_txn, mon_e.is_mret ? "MRET" : "TRAP", mon_e.is_int,
                             mon_e.mcause, mon_e.mepc, mon_e.mtval, mon_e.mstatus);
                end
            end
            if (bus.redirect_valid_o)
                check("sel_hold", {31'b0, bus.sel_exc_nret_o}, {31'b0, cur_sel});
        end
    end

    initial begin
        rst_i = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk_i);
        check("reset_ctrl", {26'b0, flush_o, stall_o, bus.we_exc_o, bus.is_int_o,
                             bus.sel_exc_nret_o, bus.redirect_valid_o}, 32'h0);
        check("reset_mcause", bus.mcause_d_o, 32'h0);
        check("reset_mstatus", bus.mstatus_d_o, 32'h0);
        rst_i  = 1'b1;
        mon_en = 1'b1;

        // Illegal instruction, ready already high: 3-cycle turnaround
        commit_valid_i = 1; pc_i = 32'h100; inst_i = 32'hFFFF_FFFF; e_illegal_inst_i = 1;
        mstatus_i = 32'h8;
        step(); idle_inputs();
        check("ill_we", {31'b0, bus.we_exc_o}, 32'h1);
        check("ill_mcause", bus.mcause_d_o, 32'h2);
        check("ill_mepc", bus.mepc_d_o, 32'h100);
        check("ill_mtval", bus.mtval_d_o, 32'hFFFF_FFFF);
        check("ill_mie", {31'b0, bus.mstatus_d_o[3]}, 32'h0);
        step();
        check("ill_redirect", {30'b0, bus.redirect_valid_o, bus.sel_exc_nret_o}, 32'h2);
        step();
        check("ill_idle", {31'b0, stall_o}, 32'h0);

        // Timer interrupt beats a simultaneous ecall
        commit_valid_i = 1; pc_i = 32'h2002; mstatus_i = 32'h1808; mie_i = 32'h80;
        mtip_i = 1; e_ecall_i = 1;
        step(); idle_inputs();
        check("tmr_mcause", bus.mcause_d_o, 32'h8000_0007);
        check("tmr_is_int", {31'b0, bus.is_int_o}, 32'h1);
        check("tmr_mip", bus.mip_d_o, 32'h80);
        check("tmr_mstatus", bus.mstatus_d_o, 32'h1880);
        check("tmr_mepc", bus.mepc_d_o, 32'h2000);
        repeat (2) step();

        // Masked interrupt, then unmasked lines without commit: no event either way
        commit_valid_i = 1; mstatus_i = 32'h8; mie_i = 32'h0; meip_i = 1;
        repeat (10) step();
        commit_valid_i = 0; mie_i = 32'hFFFF_FFFF;
        repeat (3) step();
        check("masked_stall", {31'b0, stall_o}, 32'h0);
        idle_inputs();

        // MRET restores MIE from MPIE
        commit_valid_i = 1; mret_i = 1; mstatus_i = 32'h1880;
        step(); idle_inputs();
        check("mret_mstatus", bus.mstatus_d_o, 32'h1888);
        check("mret_we", {31'b0, bus.we_exc_o}, 32'h0);
        step();
        check("mret_sel", {31'b0, bus.sel_exc_nret_o}, 32'h1);
        step();

        // Backpressure with fresh exception flags presented while busy
        commit_valid_i = 1; e_ecall_i = 1; pc_i = 32'h300; bus.redirect_ready_i = 0;
        step();
        repeat (5) begin
            commit_valid_i = 1; e_illegal_inst_i = 1; e_ebreak_i = 1; mret_i = 1;
            step();
            check("bp_hold", {30'b0, bus.redirect_valid_o, stall_o}, 32'h3);
        end
        idle_inputs();
        step();
        check("bp_release", {31'b0, stall_o}, 32'h0);

        // Reset while in REDIRECT
        commit_valid_i = 1; e_store_misaligned_i = 1; badaddr_i = 32'h1235; bus.redirect_ready_i = 0;
        step(); idle_inputs(); bus.redirect_ready_i = 0;
        step();
        #2 rst_i = 1'b0;
        model_reset();
        #1;
        check("rst_mid_ctrl", {26'b0, flush_o, stall_o, bus.we_exc_o, bus.is_int_o,
                               bus.sel_exc_nret_o, bus.redirect_valid_o}, 32'h0);
        check("rst_mid_mtval", bus.mtval_d_o, 32'h0);
        @(negedge clk_i);
        rst_i = 1'b1;
        bus.redirect_ready_i = 1;
        commit_valid_i = 1; e_ecall_i = 1; pc_i = 32'h400;
        step(); idle_inputs();
        check("post_rst_mcause", bus.mcause_d_o, 32'd11);
        repeat (2) step();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            commit_valid_i       = ($urandom_range(0, 3) != 0);
            pc_i                 = $urandom;
            inst_i               = $urandom;
            badaddr_i            = $urandom;
            e_inst_misaligned_i  = ($urandom_range(0, 9) == 0);
            e_illegal_inst_i     = ($urandom_range(0, 9) == 0);
            e_ecall_i            = ($urandom_range(0, 9) == 0);
            e_ebreak_i           = ($urandom_range(0, 9) == 0);
            e_load_misaligned_i  = ($urandom_range(0, 9) == 0);
            e_store_misaligned_i = ($urandom_range(0, 9) == 0);
            mret_i               = ($urandom_range(0, 5) == 0);
            meip_i               = ($urandom_range(0, 5) == 0);
            mtip_i               = ($urandom_range(0, 5) == 0);
            msip_i               = ($urandom_range(0, 5) == 0);
            mstatus_i            = $urandom;
            mie_i                = ($urandom_range(0, 1) != 0) ? $urandom : 32'h888;
            bus.redirect_ready_i = ($urandom_range(0, 2) != 0);
            step();
        end
        idle_inputs();
        repeat (4) step();
        check("queue_drained", exp_q.size(), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
